// File: rtl/burst_client_pkg.sv
// Shared types and parameter defaults for the burst client and its request queue.
package burst_client_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2
  } state_t;

  localparam int SIZE_W_DEFAULT  = 3;
  localparam int DEPTH_DEFAULT   = 4;
  localparam int TIMEOUT_DEFAULT = 15;

endpackage

// File: rtl/burst_client_req_fifo.sv
// Request queue: circular buffer with registered occupancy flags.
module req_fifo #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("req_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]      count_reg, count_next;
  logic             empty_reg, full_reg;
  logic             push_ok, pop_ok;

  // A push while full is dropped even when a pop happens on the same edge.
  assign push_ok = push & ~full_reg;
  assign pop_ok  = pop & ~empty_reg;

  always_comb begin
    count_next = count_reg;
    if (push_ok && !pop_ok) begin
      count_next = count_reg + (AW+1)'(1);
    end else if (!push_ok && pop_ok) begin
      count_next = count_reg - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      empty_reg  <= 1'b1;
      full_reg   <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_next;
      empty_reg <= (count_next == '0);
      full_reg  <= (count_next == (AW+1)'(DEPTH));
    end
  end

  // Storage carries no reset; contents are only observed while non-empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= din;
  end

  assign head  = mem[rd_ptr_reg];
  assign empty = empty_reg;
  assign full  = full_reg;

endmodule

// File: rtl/burst_client.sv
// Burst client: queues burst requests, presents them to a server, and times
// the granted transfer or aborts after a grant timeout.
module burst_client
  import burst_client_pkg::*;
#(
  parameter int SIZE_W  = SIZE_W_DEFAULT,
  parameter int DEPTH   = DEPTH_DEFAULT,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_in,
  input  logic [SIZE_W-1:0] size_in,
  input  logic              resp,
  output logic              req_out,
  output logic [SIZE_W-1:0] size_out,
  output logic              done,
  output logic              err,
  output logic              full,
  output logic              ovf
);

  if ((TIMEOUT < 1) || (TIMEOUT > 255)) begin : g_bad_timeout
    $error("burst_client: TIMEOUT must be in 1..255");
  end

  // Abort fires on the edge where the count would reach TIMEOUT.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_t            state_reg, state_next;
  logic [SIZE_W-1:0] bcnt_reg, bcnt_next;
  logic [SIZE_W-1:0] size_out_reg, size_out_next;
  logic [7:0]        tcnt_reg, tcnt_next;
  logic              req_out_reg, req_out_next;
  logic              done_reg, done_next;
  logic              err_reg, err_next;
  logic              ovf_reg;
  logic              pop;
  logic              fifo_empty, fifo_full;
  logic [SIZE_W-1:0] head;

  req_fifo #(
    .WIDTH (SIZE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (req_in),
    .din   (size_in),
    .pop   (pop),
    .head  (head),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      bcnt_reg     <= '0;
      tcnt_reg     <= '0;
      req_out_reg  <= 1'b0;
      size_out_reg <= '0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
      ovf_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      bcnt_reg     <= bcnt_next;
      tcnt_reg     <= tcnt_next;
      req_out_reg  <= req_out_next;
      size_out_reg <= size_out_next;
      done_reg     <= done_next;
      err_reg      <= err_next;
      ovf_reg      <= req_in & fifo_full;
    end
  end

  always_comb begin
    state_next    = state_reg;
    bcnt_next     = bcnt_reg;
    tcnt_next     = tcnt_reg;
    req_out_next  = req_out_reg;
    size_out_next = size_out_reg;
    done_next     = 1'b0;
    err_next      = 1'b0;
    pop           = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!fifo_empty) begin
          state_next    = REQ;
          req_out_next  = 1'b1;
          size_out_next = head;
          tcnt_next     = '0;
        end
      end
      REQ: begin
        // A grant on the timeout edge takes priority over the abort.
        if (resp) begin
          state_next   = XFER;
          bcnt_next    = size_out_reg;
          tcnt_next    = '0;
          req_out_next = 1'b0;
        end else if (tcnt_reg == TIMEOUT_LAST) begin
          state_next   = IDLE;
          pop          = 1'b1;
          err_next     = 1'b1;
          tcnt_next    = '0;
          req_out_next = 1'b0;
        end else begin
          tcnt_next = tcnt_reg + 8'd1;
        end
      end
      XFER: begin
        if (bcnt_reg == '0) begin
          state_next = IDLE;
          pop        = 1'b1;
          done_next  = 1'b1;
        end else begin
          bcnt_next = bcnt_reg - SIZE_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign req_out  = req_out_reg;
  assign size_out = size_out_reg;
  assign done     = done_reg;
  assign err      = err_reg;
  assign full     = fifo_full;
  assign ovf      = ovf_reg;

endmodule

// File: tb/tb_burst_client.sv
// Scoreboard bench for burst_client: directed stimulus queues expected output
// events (edge number + value); a negedge monitor matches what the DUT shows.
module tb_burst_client;

  localparam int SIZE_W  = 3;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 15;

  localparam int K_RISE      = 0;
  localparam int K_FALL      = 1;
  localparam int K_DONE      = 2;
  localparam int K_ERR       = 3;
  localparam int K_OVF       = 4;
  localparam int K_FULL_RISE = 5;
  localparam int K_FULL_FALL = 6;

  typedef struct {
    int kind;
    int cyc;
    int val;
  } exp_t;

  exp_t exp_q[$];

  logic              clk     = 1'b0;
  logic              rst     = 1'b0;
  logic              req_in  = 1'b0;
  logic              resp    = 1'b0;
  logic [SIZE_W-1:0] size_in = '0;
  logic              req_out, done, err, full, ovf;
  logic [SIZE_W-1:0] size_out;

  int   cyc   = 0;
  int   n_vec = 0;
  int   n_err = 0;
  logic prev_req  = 1'b0;
  logic prev_full = 1'b0;
  int   p;

  burst_client #(
    .SIZE_W  (SIZE_W),
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_in   (req_in),
    .size_in  (size_in),
    .resp     (resp),
    .req_out  (req_out),
    .size_out (size_out),
    .done     (done),
    .err      (err),
    .full     (full),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kname(input int k);
    case (k)
      K_RISE:      return "req_out_rise";
      K_FALL:      return "req_out_fall";
      K_DONE:      return "done";
      K_ERR:       return "err";
      K_OVF:       return "ovf";
      K_FULL_RISE: return "full_rise";
      K_FULL_FALL: return "full_fall";
      default:     return "unknown";
    endcase
  endfunction

  task automatic expect_ev(input int kind, input int c, input int v);
    exp_t e;
    e.kind = kind;
    e.cyc  = c;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  task automatic check_out(input string name, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end else begin
      $display("ok   %s = %0d", name, got);
    end
  endtask

  task automatic observe(input int kind, input int v);
    int idx;
    idx = -1;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (idx < 0 && exp_q[i].kind == kind) idx = i;
    end
    n_vec++;
    if (idx < 0) begin
      n_err++;
      $display("FAIL %s: unexpected at edge %0d (value %0d), want no event", kname(kind), cyc, v);
    end else begin
      if (exp_q[idx].cyc != cyc || exp_q[idx].val != v) begin
        n_err++;
        $display("FAIL %s: got edge %0d value %0d, want edge %0d value %0d",
                 kname(kind), cyc, v, exp_q[idx].cyc, exp_q[idx].val);
      end else begin
        $display("ok   %s at edge %0d value %0d", kname(kind), cyc, v);
      end
      exp_q.delete(idx);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic check_all_zero(input string tag);
    check_out({tag, "_req_out"},  int'(req_out),  0);
    check_out({tag, "_size_out"}, int'(size_out), 0);
    check_out({tag, "_done"},     int'(done),     0);
    check_out({tag, "_err"},      int'(err),      0);
    check_out({tag, "_full"},     int'(full),     0);
    check_out({tag, "_ovf"},      int'(ovf),      0);
  endtask

  // Monitor: every output event is matched against the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      if (req_out && !prev_req)  observe(K_RISE, int'(size_out));
      if (!req_out && prev_req)  observe(K_FALL, 0);
      if (done)                  observe(K_DONE, 0);
      if (err)                   observe(K_ERR, 0);
      if (ovf)                   observe(K_OVF, 0);
      if (full && !prev_full)    observe(K_FULL_RISE, 0);
      if (!full && prev_full)    observe(K_FULL_FALL, 0);
    end
    prev_req  = req_out;
    prev_full = full;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running, want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    tick();
    tick();
    check_all_zero("reset");
    rst = 1'b1;

    // Single request, grant two cycles after req_out
    p = cyc + 1;
    expect_ev(K_RISE, p + 1, 3);
    expect_ev(K_FALL, p + 3, 0);
    expect_ev(K_DONE, p + 7, 0);
    req_in = 1'b1; size_in = 3'd3;
    tick();
    req_in = 1'b0;
    tick();
    tick();
    resp = 1'b1;
    tick();
    resp = 1'b0;
    wait_until(p + 12);

    // Timeout with no grant
    p = cyc + 1;
    expect_ev(K_RISE, p + 1, 5);
    expect_ev(K_FALL, p + 16, 0);
    expect_ev(K_ERR,  p + 16, 0);
    req_in = 1'b1; size_in = 3'd5;
    tick();
    req_in = 1'b0;
    wait_until(p + 25);

    // Overflow: five pushes into a four-entry queue, then serve all
    p = cyc + 1;
    expect_ev(K_RISE,      p + 1,  1);
    expect_ev(K_FULL_RISE, p + 3,  0);
    expect_ev(K_OVF,       p + 4,  0);
    expect_ev(K_FALL,      p + 5,  0);
    expect_ev(K_DONE,      p + 7,  0);
    expect_ev(K_FULL_FALL, p + 7,  0);
    expect_ev(K_RISE,      p + 8,  2);
    expect_ev(K_FALL,      p + 9,  0);
    expect_ev(K_DONE,      p + 12, 0);
    expect_ev(K_RISE,      p + 13, 3);
    expect_ev(K_FALL,      p + 14, 0);
    expect_ev(K_DONE,      p + 18, 0);
    expect_ev(K_RISE,      p + 19, 4);
    expect_ev(K_FALL,      p + 20, 0);
    expect_ev(K_DONE,      p + 25, 0);
    for (int i = 1; i <= 5; i++) begin
      req_in  = 1'b1;
      size_in = SIZE_W'(i);
      tick();
    end
    req_in = 1'b0;
    resp   = 1'b1;
    wait_until(p + 30);

    // Size zero with resp held high
    p = cyc + 1;
    expect_ev(K_RISE, p + 1, 0);
    expect_ev(K_FALL, p + 2, 0);
    expect_ev(K_DONE, p + 3, 0);
    req_in = 1'b1; size_in = 3'd0;
    tick();
    req_in = 1'b0;
    wait_until(p + 8);

    // Reset in the middle of a size-6 transfer
    p = cyc + 1;
    expect_ev(K_RISE, p + 1, 6);
    expect_ev(K_FALL, p + 2, 0);
    req_in = 1'b1; size_in = 3'd6;
    tick();
    req_in = 1'b0;
    wait_until(p + 4);
    rst = 1'b0;
    #1;
    check_all_zero("midxfer_reset");
    req_in = 1'b1; size_in = 3'd3;
    tick();
    tick();
    tick();
    // First edge after release accepts a request; a stale head would show first
    rst = 1'b1;
    size_in = 3'd2;
    p = cyc + 1;
    expect_ev(K_RISE, p + 1, 2);
    expect_ev(K_FALL, p + 2, 0);
    expect_ev(K_DONE, p + 5, 0);
    tick();
    req_in = 1'b0;
    wait_until(p + 12);
    resp = 1'b0;
    tick();

    // Push while full on the done-pop edge; grant on the timeout edge
    p = cyc + 1;
    expect_ev(K_RISE,      p + 1,  2);
    expect_ev(K_FULL_RISE, p + 3,  0);
    expect_ev(K_FALL,      p + 4,  0);
    expect_ev(K_DONE,      p + 7,  0);
    expect_ev(K_OVF,       p + 7,  0);
    expect_ev(K_FULL_FALL, p + 7,  0);
    expect_ev(K_RISE,      p + 8,  1);
    expect_ev(K_FALL,      p + 23, 0);
    expect_ev(K_DONE,      p + 25, 0);
    expect_ev(K_RISE,      p + 26, 0);
    expect_ev(K_FALL,      p + 27, 0);
    expect_ev(K_DONE,      p + 28, 0);
    expect_ev(K_RISE,      p + 29, 3);
    expect_ev(K_FALL,      p + 30, 0);
    expect_ev(K_DONE,      p + 34, 0);
    req_in = 1'b1;
    size_in = 3'd2; tick();
    size_in = 3'd1; tick();
    size_in = 3'd0; tick();
    size_in = 3'd3; tick();
    req_in = 1'b0;
    resp   = 1'b1;
    tick();
    resp = 1'b0;
    wait_until(p + 6);
    req_in = 1'b1; size_in = 3'd7;
    tick();
    req_in = 1'b0;
    wait_until(p + 22);
    resp = 1'b1;
    wait_until(p + 36);
    resp = 1'b0;
    wait_until(p + 45);

    check_out("events_pending", exp_q.size(), 0);
    foreach (exp_q[i]) begin
      $display("  missing %s at edge %0d value %0d", kname(exp_q[i].kind), exp_q[i].cyc, exp_q[i].val);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/burst_client.md
BURST_CLIENT -- requirements
Module: burst_client

Interface
REQ-001 Parameter SIZE_W, default 3: width of the burst-size field in bits.
REQ-002 Parameter DEPTH, default 4: request-queue entries; a power of two, at least 2.
REQ-003 Parameter TIMEOUT, default 15: REQ-state cycles allowed without resp before abort; range 1..255.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 req_in  input  1  request strobe; one request per high cycle.
REQ-007 size_in  input  SIZE_W  burst size, valid with req_in.
REQ-008 resp  input  1  server grant for the presented request.
REQ-009 req_out  output  1  request presented to the server.
REQ-010 size_out  output  SIZE_W  size of the presented request.
REQ-011 done  output  1  one-cycle pulse: burst complete.
REQ-012 err  output  1  one-cycle pulse: request aborted on timeout.
REQ-013 full  output  1  queue holds DEPTH entries.
REQ-014 ovf  output  1  one-cycle pulse: a request was dropped because the queue was full.

Function
REQ-015 All outputs SHALL be driven from registers, with no combinational input-to-output path.
REQ-016 A request (req_in=1 at an edge) SHALL be written to the FIFO queue when full=0; when full=1 it SHALL be discarded and ovf SHALL pulse on the next cycle.
REQ-017 A push and a pop on the same edge SHALL leave the occupancy unchanged; a push while full SHALL be dropped even if a pop occurs on that edge.
REQ-018 The state machine SHALL have three states: IDLE, REQ and XFER.
REQ-019 IDLE->REQ SHALL occur at the first edge where the queue is non-empty; req_out=1 and size_out=head size SHALL take effect from that edge.
REQ-020 Latency: a request pushed at edge t into an empty queue with the block idle SHALL have req_out high from edge t+1.
REQ-021 In REQ, req_out and size_out SHALL stay stable until exit; the timeout counter SHALL increment each REQ cycle without resp.
REQ-022 REQ->XFER SHALL occur on resp=1, loading the burst counter with the head size and clearing the timeout counter and req_out.
REQ-023 REQ->IDLE SHALL occur on the edge where the counter would reach TIMEOUT with resp=0; the head SHALL be popped and err pulsed; resp on that same edge SHALL win (go to XFER).
REQ-024 In XFER the counter SHALL decrement each cycle; at count 0 the machine SHALL pop the head, pulse done, and go to IDLE. XFER therefore lasts size+1 cycles, and size 0 lasts 1 cycle.
REQ-025 resp SHALL be ignored in IDLE and XFER.
REQ-026 Back-to-back operation: after done or err, the next queued request SHALL raise req_out one cycle after the return to IDLE.
REQ-027 Arithmetic: the counter SHALL be SIZE_W bits and SHALL never wrap below 0; the timeout counter SHALL be 8 bits.

Reset
REQ-028 rst=0 SHALL asynchronously force IDLE, empty the queue, and clear both counters; req_out, size_out, done, err, full and ovf SHALL all read 0.
REQ-029 Reset during REQ or XFER SHALL abandon the burst with no done or err pulse; requests arriving while rst=0 SHALL be ignored.
REQ-030 After rst deasserts, the first rising edge SHALL accept req_in normally.

Structure
REQ-031 A package burst_client_pkg SHALL hold the state typedef (IDLE, REQ, XFER) and the default values for SIZE_W, DEPTH and TIMEOUT.
REQ-032 The queue SHALL be a separate sub-module, req_fifo, parametrised by width (SIZE_W) and DEPTH, providing push, pop, head, empty and full.
REQ-033 The top level SHALL contain only the state machine, the counters and the output registers.

Verification
REQ-034 Single request: req_in with size_in=3, then resp two cycles after req_out -> req_out for 2 cycles, XFER for 4 cycles, one done pulse, err and ovf stay 0.
REQ-035 Timeout: req_in with size_in=5 and resp held 0 -> req_out high for 15 cycles, then an err pulse, the queue empties, and done never pulses.
REQ-036 Overflow: 5 consecutive req_in with sizes 1..5 while resp=0 (DEPTH=4) -> full high after the 4th, ovf pulses once, and the bursts served carry sizes 1,2,3,4 in order.
REQ-037 Size zero with an immediate grant: size_in=0, resp=1 throughout -> done pulses exactly 3 cycles after req_in.
REQ-038 Reset mid-XFER: rst=0 during XFER of size 6 -> all outputs 0 immediately, no done pulse, and the queue is empty after release.
REQ-039 Simultaneous events: push while full on the same edge as a done pop -> occupancy stays DEPTH-1 and ovf pulses; resp on the timeout edge -> XFER entered and no err.
